// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
//   IM_AW  : instruction-memory address width (64 words)
//   WORD_W : instruction word width
//   BYTE_W : width of the serial byte stream
package prog_loader_pkg;

    localparam int IM_AW  = 6;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        CHK   = 3'd4,
        FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/prog_loader_adder.sv
// Six-bit ripple-carry adder used for the loader's word counter.
//   X, Y : addends
//   Cin  : carry in
//   S    : sum (carry out of bit 5 is dropped; the counter never reaches it)
module FA_6bit_adder (
    input  logic [5:0] X,
    input  logic [5:0] Y,
    input  logic       Cin,
    output logic [5:0] S
);

    logic [5:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 6; i++) begin : g_fa
        assign S[i] = X[i] ^ Y[i] ^ c[i];
        if (i < 5) begin : g_carry
            assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (high byte first) and writes
// len+1 16-bit words into instruction memory, then checks a trailing
// XOR checksum byte. The processor is held until a load completes cleanly.
//   clk, clr_n         : clock, asynchronous active-low reset
//   start, len         : begin a load of len+1 words (accepted in IDLE only)
//   rx_data/valid/ready: byte stream handshake
//   im_we/addr/wdata   : instruction-memory write port
//   cpu_hold, busy     : processor freeze, load in progress
//   done, err          : end-of-load pulse, sticky checksum error
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [IM_AW-1:0]  len,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [IM_AW-1:0]    cnt_q, cnt_inc, len_q;
    logic [BYTE_W-1:0]   hi_q, chk_q;
    logic [IM_AW-1:0]    addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                err_q, hold_q;
    logic                xfer;

    FA_6bit_adder u_cnt_inc (
        .X   (cnt_q),
        .Y   (6'b000001),
        .Cin (1'b0),
        .S   (cnt_inc)
    );

    // All handshake/strobe outputs decode registered state only.
    assign rx_ready = (state_q == HI) || (state_q == LO) || (state_q == CHK);
    assign xfer     = rx_valid && rx_ready;
    assign im_we    = (state_q == WRITE);
    assign done     = (state_q == FIN);
    assign busy     = (state_q != IDLE);
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign err      = err_q;
    assign cpu_hold = hold_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = HI;
            HI:      if (xfer)  state_d = LO;
            LO:      if (xfer)  state_d = WRITE;
            WRITE:   state_d = (cnt_q == len_q) ? CHK : HI;
            CHK:     if (xfer)  state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            len_q   <= '0;
            hi_q    <= '0;
            chk_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    len_q  <= len;
                    cnt_q  <= '0;
                    chk_q  <= '0;
                    err_q  <= 1'b0;
                    hold_q <= 1'b1;
                end
                HI: if (xfer) begin
                    hi_q  <= rx_data;
                    chk_q <= chk_q ^ rx_data;
                end
                // The write port is loaded here so im_addr/im_wdata are
                // already valid in the WRITE cycle and hold afterwards.
                LO: if (xfer) begin
                    chk_q   <= chk_q ^ rx_data;
                    addr_q  <= cnt_q;
                    wdata_q <= {hi_q, rx_data};
                end
                WRITE: if (cnt_q != len_q) cnt_q <= cnt_inc;
                CHK: if (xfer) err_q <= (rx_data != chk_q);
                FIN: if (!err_q) hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [5:0]  len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [5:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [64];
    logic [5:0]  addr_log [128];
    logic [15:0] wbuf [64];
    int we_cnt = 0;
    int done_cnt = 0;
    int viol = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .len      (len),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // External instruction memory and event counters
    always @(posedge clk) begin
        if (im_we) begin
            mem[im_addr] = im_wdata;
            if (we_cnt < 128) addr_log[we_cnt] = im_addr;
            we_cnt++;
        end
        if (done) done_cnt++;
    end

    always @(negedge clk) if (im_we && rx_ready) viol++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'hA5;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'hEE;
    endtask

    // Start is raised together with a valid byte that must not be consumed.
    task automatic start_load(input logic [5:0] l);
        @(negedge clk);
        start    = 1'b1;
        len      = l;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", rx_ready, 1);
    endtask

    task automatic run_load(input int n, input logic [7:0] ck, input bit gap,
                            input bit spam, input bit exp_err, input bit exp_hold);
        start_load(6'(n));
        for (int w = 0; w <= n; w++) begin
            if (spam && w == 1) start = 1'b1;
            send_byte(wbuf[w][15:8], gap);
            send_byte(wbuf[w][7:0], gap);
        end
        start = 1'b0;
        send_byte(ck, gap);
        check("done_pulse", done, 1);
        check("err_at_fin", err, 32'(exp_err));
        @(posedge clk);
        #1;
        check("done_single", done, 0);
        check("busy_after_fin", busy, 0);
        check("hold_after_fin", cpu_hold, 32'(exp_hold));
    endtask

    initial begin
        int we0, dn0;
        logic [7:0] ck;
        clr_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        rx_valid = 1'b0;
        rx_data  = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_ready", rx_ready, 0);
        check("rst_we", im_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", im_addr, 0);
        check("rst_wdata", im_wdata, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Single word 0x1234, checksum 0x12^0x34 = 0x26
        we0 = we_cnt; dn0 = done_cnt;
        wbuf[0] = 16'h1234;
        run_load(0, 8'h26, 0, 0, 0, 0);
        check("t1_we_cnt", we_cnt - we0, 1);
        check("t1_mem0", mem[0], 16'h1234);
        check("t1_done_cnt", done_cnt - dn0, 1);
        check("t1_addr_hold", im_addr, 0);
        check("t1_wdata_hold", im_wdata, 16'h1234);

        // Three words; XOR of A0,01,B0,02,C0,03 is 0xD0
        we0 = we_cnt;
        wbuf[0] = 16'hA001; wbuf[1] = 16'hB002; wbuf[2] = 16'hC003;
        run_load(2, 8'hD0, 0, 0, 0, 0);
        check("t2_we_cnt", we_cnt - we0, 3);
        check("t2_order0", addr_log[we0], 0);
        check("t2_order1", addr_log[we0+1], 1);
        check("t2_order2", addr_log[we0+2], 2);
        check("t2_mem0", mem[0], 16'hA001);
        check("t2_mem1", mem[1], 16'hB002);
        check("t2_mem2", mem[2], 16'hC003);

        // Bad checksum leaves processor held; a good load releases it
        wbuf[0] = 16'h1234;
        run_load(0, 8'h00, 0, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_err_sticky", err, 1);
        check("t3_hold_sticky", cpu_hold, 1);
        run_load(0, 8'h26, 0, 0, 0, 0);
        check("t3_err_cleared", err, 0);

        // rx_valid toggling; 5A^C3^3C^96 = 0x33
        we0 = we_cnt; viol = 0;
        wbuf[0] = 16'h5AC3; wbuf[1] = 16'h3C96;
        run_load(1, 8'h33, 1, 0, 0, 0);
        check("t4_we_cnt", we_cnt - we0, 2);
        check("t4_mem0", mem[0], 16'h5AC3);
        check("t4_mem1", mem[1], 16'h3C96);
        check("t4_ready_in_write", viol, 0);

        // Reset after the third byte of a four-word load
        we0 = we_cnt; dn0 = done_cnt;
        wbuf[0] = 16'hDEAD; wbuf[1] = 16'hBEEF;
        start_load(6'd3);
        send_byte(wbuf[0][15:8], 0);
        send_byte(wbuf[0][7:0], 0);
        send_byte(wbuf[1][15:8], 0);
        #2;
        clr_n = 1'b0;
        #1;
        check("t5_busy_async", busy, 0);
        check("t5_hold_async", cpu_hold, 1);
        check("t5_ready_async", rx_ready, 0);
        check("t5_wdata_async", im_wdata, 0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt - dn0, 0);
        check("t5_partial_we", we_cnt - we0, 1);
        check("t5_partial_mem", mem[0], 16'hDEAD);
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h4444; wbuf[3] = 16'h8888;
        run_load(3, 8'h00, 0, 0, 0, 0);
        check("t5_mem0", mem[0], 16'h1111);
        check("t5_mem3", mem[3], 16'h8888);

        // Full 64-word load with start held high through the body
        we0 = we_cnt; dn0 = done_cnt;
        ck = 8'h00;
        for (int w = 0; w < 64; w++) begin
            wbuf[w] = {8'(w), 8'(w + 100)};
            ck = ck ^ 8'(w) ^ 8'(w + 100);
        end
        run_load(63, ck, 0, 1, 0, 0);
        check("t6_we_cnt", we_cnt - we0, 64);
        check("t6_last_addr", addr_log[we0+63], 63);
        check("t6_addr_hold", im_addr, 63);
        check("t6_mem0", mem[0], 16'h0064);
        check("t6_mem63", mem[63], {8'd63, 8'd163});
        repeat (3) @(posedge clk);
        #1;
        check("t6_done_cnt", done_cnt - dn0, 1);
        check("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
